// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared types for the instruction/data cache RAM arbiter.
// Covers the FSM state encoding, the grant codes and the counter width.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10
    } grant_t;

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Cache miss ports and the RAM port of the arbiter, bundled together.
// The slave modport is the arbiter's view; the master modport is the view of the caches and the RAM.
interface pipe_mem_arbiter_if #(
    parameter int ADDR_W = 5
);
    logic              i_strobe;
    logic [31:0]       i_addr;
    logic              i_ready;
    logic [31:0]       i_dout;
    logic              d_strobe;
    logic              d_rw;
    logic [31:0]       d_addr;
    logic [31:0]       d_din;
    logic              d_ready;
    logic [31:0]       d_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [31:0]       mem_dout;

    modport slave (
        input  i_strobe, i_addr, d_strobe, d_rw, d_addr, d_din, mem_dout,
        output i_ready, i_dout, d_ready, d_dout, mem_addr, mem_din, mem_we
    );

    modport master (
        output i_strobe, i_addr, d_strobe, d_rw, d_addr, d_din, mem_dout,
        input  i_ready, i_dout, d_ready, d_dout, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/pipe_mem_arbiter_select.sv
// Combinational winner selection. Data has priority, but it yields to a waiting
// instruction fetch once the data side has reached its streak limit.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic             i_strobe,
    input  logic             d_strobe,
    input  logic [CNT_W-1:0] streak,
    output grant_t           next_grant
);
    // NOTE: default first so every path assigns next_grant and no latch is inferred.
    always_comb begin
        next_grant = GNT_NONE;
        if (d_strobe && !(i_strobe && streak == CNT_W'(MAX_D_STREAK)))
            next_grant = GNT_D;
        else if (i_strobe)
            next_grant = GNT_I;
    end
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one data RAM between the icache and dcache miss ports.
// Each access is a fixed wait followed by a one-cycle ready pulse to the winner.
module pipe_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES  = 5,
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 5
) (
    input  logic              clock,
    input  logic              resetn,
    pipe_mem_arbiter_if.slave bus,
    output logic              busy,
    output grant_t            grant
);
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  streak;
    logic              lat_rw;
    grant_t            next_grant;
    logic [ADDR_W-1:0] win_addr;

    mem_arb_select #(.MAX_D_STREAK(MAX_D_STREAK)) u_select (
        .i_strobe   (bus.i_strobe),
        .d_strobe   (bus.d_strobe),
        .streak     (streak),
        .next_grant (next_grant)
    );

    always_comb begin
        win_addr = (next_grant == GNT_D) ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            busy         <= 1'b0;
            grant        <= GNT_NONE;
            cnt          <= '0;
            streak       <= '0;
            lat_rw       <= 1'b0;
            bus.i_ready  <= 1'b0;
            bus.d_ready  <= 1'b0;
            bus.i_dout   <= '0;
            bus.d_dout   <= '0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.mem_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_grant != GNT_NONE) begin
                        state        <= BUSY;
                        busy         <= 1'b1;
                        grant        <= next_grant;
                        cnt          <= '0;
                        bus.mem_addr <= win_addr;
                        bus.mem_din  <= (next_grant == GNT_D) ? bus.d_din : '0;
                        lat_rw       <= (next_grant == GNT_D) && bus.d_rw;
                        bus.mem_we   <= (next_grant == GNT_D) && bus.d_rw;
                        // Streak only grows while an instruction fetch is actually waiting.
                        if (next_grant == GNT_D && bus.i_strobe) begin
                            if (streak != CNT_W'(MAX_D_STREAK))
                                streak <= streak + CNT_W'(1);
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                BUSY: begin
                    bus.mem_we <= 1'b0;
                    if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                        state        <= RESP;
                        bus.mem_addr <= '0;
                        bus.mem_din  <= '0;
                        if (grant == GNT_I) begin
                            bus.i_dout  <= bus.mem_dout;
                            bus.i_ready <= 1'b1;
                        end else begin
                            bus.d_ready <= 1'b1;
                            if (!lat_rw)
                                bus.d_dout <= bus.mem_dout;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state       <= RECOVER;
                    bus.i_ready <= 1'b0;
                    bus.d_ready <= 1'b0;
                end
                RECOVER: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= GNT_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: a WAIT_CYCLES=5 instance for most scenarios
// and a WAIT_CYCLES=1 instance for the minimum-wait timing.
module tb_pipe_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int W    = 5;
    localparam int W1   = 1;
    localparam int MAXS = 4;
    localparam int AW   = 5;

    logic   clock  = 1'b0;
    logic   resetn = 1'b0;
    logic   busy, busy1;
    grant_t grant, grant1;
    int     checks = 0;
    int     passes = 0;

    pipe_mem_arbiter_if #(.ADDR_W(AW)) bus  ();
    pipe_mem_arbiter_if #(.ADDR_W(AW)) bus1 ();

    pipe_mem_arbiter #(.WAIT_CYCLES(W), .MAX_D_STREAK(MAXS), .ADDR_W(AW)) u_dut (
        .clock (clock), .resetn (resetn), .bus (bus), .busy (busy), .grant (grant)
    );

    pipe_mem_arbiter #(.WAIT_CYCLES(W1), .MAX_D_STREAK(MAXS), .ADDR_W(AW)) u_dut1 (
        .clock (clock), .resetn (resetn), .bus (bus1), .busy (busy1), .grant (grant1)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int k);
        return (k == 3) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(k));
    endfunction

    // Synchronous-read RAMs, reloaded with known contents while reset is low.
    logic [31:0] ram  [32];
    logic [31:0] ram1 [32];
    always @(posedge clock) begin
        if (!resetn) begin
            for (int k = 0; k < 32; k++) ram[k] <= init_word(k);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_din;
        end
        bus.mem_dout <= ram[bus.mem_addr];
    end
    always @(posedge clock) begin
        if (!resetn) begin
            for (int k = 0; k < 32; k++) ram1[k] <= init_word(k);
        end else if (bus1.mem_we) begin
            ram1[bus1.mem_addr] <= bus1.mem_din;
        end
        bus1.mem_dout <= ram1[bus1.mem_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one access on u_dut; n counts rising edges from the sample edge (n=1) to ready.
    task automatic access(input logic is_d, input logic rw, input logic [31:0] addr,
                          input logic [31:0] din, output int n, output logic [31:0] data,
                          output int we_cnt, output logic [AW-1:0] we_addr,
                          output logic [31:0] we_din, output logic gnt_bad);
        grant_t exp_g;
        exp_g   = is_d ? GNT_D : GNT_I;
        n       = 0;
        we_cnt  = 0;
        we_addr = '0;
        we_din  = '0;
        gnt_bad = 1'b0;
        if (is_d) begin
            bus.d_strobe = 1'b1; bus.d_rw = rw; bus.d_addr = addr; bus.d_din = din;
        end else begin
            bus.i_strobe = 1'b1; bus.i_addr = addr;
        end
        while (n < 40) begin
            tick();
            n++;
            if (bus.mem_we) begin
                we_cnt++; we_addr = bus.mem_addr; we_din = bus.mem_din;
            end
            if (grant !== exp_g) gnt_bad = 1'b1;
            if (is_d ? bus.d_ready : bus.i_ready) break;
        end
        data = is_d ? bus.d_dout : bus.i_dout;
        bus.d_strobe = 1'b0;
        bus.i_strobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({busy, grant, bus.i_ready, bus.d_ready, bus.mem_we} !== 6'b0)
            $display("FAIL reset_ctrl: got %b required 0", {busy, grant, bus.i_ready, bus.d_ready, bus.mem_we});
        else passes++;
        checks++;
        if ({bus.i_dout, bus.d_dout, bus.mem_din, bus.mem_addr} !== '0)
            $display("FAIL reset_data: got %h required 0", {bus.i_dout, bus.d_dout, bus.mem_din, bus.mem_addr});
        else passes++;
        resetn = 1'b1;
        tick();
        checks++;
        if ({busy, grant} !== 3'b0) $display("FAIL reset_release_idle: got %b required 0", {busy, grant});
        else passes++;
    endtask

    task automatic test_d_read();
        int n, wc; logic [31:0] data, wd; logic [AW-1:0] wa; logic gb;
        access(1'b1, 1'b0, 32'h0000_000C, 32'h0, n, data, wc, wa, wd, gb);
        checks++;
        if (n !== W + 1) $display("FAIL d_read_latency: got %0d required %0d", n, W + 1);
        else passes++;
        checks++;
        if (data !== 32'hDEAD_BEEF) $display("FAIL d_read_data: got %h required deadbeef", data);
        else passes++;
        checks++;
        if (gb !== 1'b0) $display("FAIL d_read_grant: got grant drop %b required 0", gb);
        else passes++;
        checks++;
        if (wc !== 0) $display("FAIL d_read_no_we: got %0d write cycles required 0", wc);
        else passes++;
    endtask

    task automatic test_d_write();
        int n, wc; logic [31:0] data, wd; logic [AW-1:0] wa; logic gb;
        access(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, n, data, wc, wa, wd, gb);
        checks++;
        if (wc !== 1) $display("FAIL d_write_we_cycles: got %0d required 1", wc);
        else passes++;
        checks++;
        if (wa !== 5'd4) $display("FAIL d_write_addr: got %0d required 4", wa);
        else passes++;
        checks++;
        if (wd !== 32'h1234_5678) $display("FAIL d_write_din: got %h required 12345678", wd);
        else passes++;
        checks++;
        if (n !== W + 1) $display("FAIL d_write_latency: got %0d required %0d", n, W + 1);
        else passes++;
        checks++;
        if (data !== 32'hDEAD_BEEF) $display("FAIL d_write_dout_hold: got %h required deadbeef", data);
        else passes++;
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, n, data, wc, wa, wd, gb);
        checks++;
        if (data !== 32'h1234_5678) $display("FAIL d_readback: got %h required 12345678", data);
        else passes++;
    endtask

    task automatic test_simultaneous();
        int n = 0, d_n = -1, i_n = -1;
        logic i_at_d = 1'b0;
        bus.d_strobe = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h0000_000C;
        bus.i_strobe = 1'b1; bus.i_addr = 32'h0000_0008;
        while (n < 60) begin
            tick();
            n++;
            if (bus.d_ready) begin
                d_n = n; i_at_d = bus.i_ready; bus.d_strobe = 1'b0;
            end
            if (bus.i_ready) begin
                i_n = n; bus.i_strobe = 1'b0;
                break;
            end
        end
        bus.d_strobe = 1'b0;
        bus.i_strobe = 1'b0;
        tick();
        tick();
        checks++;
        if (d_n !== W + 1) $display("FAIL both_d_first: got d_ready at %0d required %0d", d_n, W + 1);
        else passes++;
        checks++;
        if (i_n - d_n !== W + 3) $display("FAIL both_i_gap: got %0d required %0d", i_n - d_n, W + 3);
        else passes++;
        checks++;
        if (i_at_d !== 1'b0) $display("FAIL both_nonowner_ready: got %b required 0", i_at_d);
        else passes++;
        checks++;
        if (bus.i_dout !== 32'hA500_0002) $display("FAIL both_i_data: got %h required a5000002", bus.i_dout);
        else passes++;
    endtask

    task automatic test_streak();
        grant_t g [10];
        int idx = 0, n = 0;
        logic prev = busy;
        for (int k = 0; k < 10; k++) g[k] = GNT_NONE;
        bus.d_strobe = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h0; bus.i_strobe = 1'b1; bus.i_addr = 32'h4;
        while (idx < 10 && n < 150) begin
            tick();
            n++;
            if (busy && !prev) begin
                g[idx] = grant; idx++;
            end
            prev = busy;
        end
        bus.d_strobe = 1'b0;
        bus.i_strobe = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick(); n++;
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            grant_t exp_g;
            exp_g = (k == 4 || k == 9) ? GNT_I : GNT_D;
            checks++;
            if (g[k] !== exp_g) $display("FAIL streak_grant_%0d: got %b required %b", k, g[k], exp_g);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, wc; logic [31:0] data, wd; logic [AW-1:0] wa; logic gb;
        logic stray = 1'b0;
        bus.d_strobe = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h0000_000C;
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, grant, bus.i_ready, bus.d_ready, bus.mem_we, bus.mem_addr} !== '0)
            $display("FAIL midreset_ctrl: got %b required 0", {busy, grant, bus.i_ready, bus.d_ready, bus.mem_we, bus.mem_addr});
        else passes++;
        checks++;
        if ({bus.d_dout, bus.i_dout, bus.mem_din} !== '0)
            $display("FAIL midreset_data: got %h required 0", {bus.d_dout, bus.i_dout, bus.mem_din});
        else passes++;
        bus.d_strobe = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (12) begin
            tick();
            if (bus.d_ready || bus.i_ready || busy) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) $display("FAIL midreset_no_ready: got activity %b required 0", stray);
        else passes++;
        access(1'b0, 1'b0, 32'h0000_0004, 32'h0, n, data, wc, wa, wd, gb);
        checks++;
        if (n !== W + 1) $display("FAIL after_reset_latency: got %0d required %0d", n, W + 1);
        else passes++;
        checks++;
        if (data !== 32'hA500_0001) $display("FAIL after_reset_i_data: got %h required a5000001", data);
        else passes++;
    endtask

    task automatic test_wait_one();
        int n = 0, r1 = -1, r2 = -1;
        bus1.i_strobe = 1'b1; bus1.i_addr = 32'h0000_0008;
        while (n < 20) begin
            tick();
            n++;
            if (bus1.i_ready) begin
                if (r1 < 0) r1 = n;
                else begin
                    r2 = n; break;
                end
            end
        end
        bus1.i_strobe = 1'b0;
        repeat (3) tick();
        checks++;
        if (r1 !== W1 + 1) $display("FAIL w1_latency: got %0d required %0d", r1, W1 + 1);
        else passes++;
        checks++;
        if (r2 - r1 !== W1 + 3) $display("FAIL w1_second_access: got gap %0d required %0d", r2 - r1, W1 + 3);
        else passes++;
        checks++;
        if (busy1 !== 1'b0) $display("FAIL w1_idle_after: got busy %b required 0", busy1);
        else passes++;
    endtask

    initial begin
        bus.i_strobe  = 1'b0; bus.i_addr  = '0; bus.d_strobe  = 1'b0; bus.d_rw  = 1'b0; bus.d_addr  = '0; bus.d_din  = '0;
        bus1.i_strobe = 1'b0; bus1.i_addr = '0; bus1.d_strobe = 1'b0; bus1.d_rw = 1'b0; bus1.d_addr = '0; bus1.d_din = '0;
        test_reset();
        test_d_read();
        test_d_write();
        test_simultaneous();
        test_streak();
        test_reset_mid();
        test_wait_one();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
